// File: rtl/uart_decoder.sv
// -----------------------------------------------------------------------------
// uart_decoder
//
// UART receive-side decoder. Takes one asynchronous serial line (idle high,
// LSB first) and turns it back into bytes. It uses the same configuration
// fields as the UART encoder: parity mode, stop-bit count and baud divisor.
// Bytes with parity or stop-bit errors are still delivered, and flags mark them.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   uart_dec     serial input line (asynchronous to clk)
//   parity       00/11 none, 01 odd, 10 even
//   stop_sel     0: one stop bit, 1: two stop bits
//   baudcontrol  bit period minus one, in clk cycles (values below 3 act as 3)
//   data_out     last received byte, held until the next frame completes
//   data_valid   one-cycle pulse: data_out / parity_err / frame_err updated
//   parity_err   parity mismatch for the byte flagged by data_valid
//   frame_err    a stop bit was sampled low for that byte
//   busy         high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_decoder #(
  parameter int BAUD_W      = 24,
  parameter int SYNC_STAGES = 2    // minimum 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_dec,
  input  logic [1:0]        parity,
  input  logic              stop_sel,
  input  logic [BAUD_W-1:0] baudcontrol,
  output logic [7:0]        data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2
  } state_e;

  // Input synchroniser plus one edge-detect flop.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line;

  state_e                 state_q, state_d;
  logic [BAUD_W-1:0]      cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [1:0]             par_cfg_q, par_cfg_d;
  logic                   stop_cfg_q, stop_cfg_d;
  logic [BAUD_W-1:0]      div_q, div_d;
  logic                   perr_q, perr_d;   // parity flag of frame in flight
  logic                   ferr_q, ferr_d;   // stop-bit flag of frame in flight
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_out_q, ferr_out_d;
  logic                   busy_q, busy_d;

  logic [BAUD_W-1:0]      div_eff;
  logic                   expired;
  logic                   fall;
  logic                   par_xor;
  logic                   ferr_sample;

  assign line        = sync_q[SYNC_STAGES-1];
  assign fall        = prev_q & ~line;
  assign expired     = (cnt_q == '0);
  // Below 3 the half-bit start delay collapses and sampling can no longer
  // land near bit centres, so the divisor is clamped.
  assign div_eff     = (baudcontrol < BAUD_W'(3)) ? BAUD_W'(3) : baudcontrol;
  assign par_xor     = ^{shift_q, line};
  assign ferr_sample = ferr_q | ~line;

  // NOTE: every register in this block, including the shift register, has a
  // reset value, so a rst mid-frame leaves no trace of the partial byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '1;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_cfg_q  <= '0;
      stop_cfg_q <= 1'b0;
      div_q      <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the synchroniser chain depends on this to delay by one stage per flop.
      sync_q     <= {sync_q[SYNC_STAGES-2:0], uart_dec};
      prev_q     <= line;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_cfg_q  <= par_cfg_d;
      stop_cfg_q <= stop_cfg_d;
      div_q      <= div_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = expired ? cnt_q : cnt_q - BAUD_W'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_cfg_d  = par_cfg_q;
    stop_cfg_d = stop_cfg_q;
    div_d      = div_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;

    unique case (state_q)
      S_IDLE: begin
        // Only a genuine 1->0 transition starts a frame; a line stuck low
        // (break) cannot retrigger.
        if (fall) begin
          par_cfg_d  = parity;
          stop_cfg_d = stop_sel;
          div_d      = div_eff;
          cnt_d      = div_eff >> 1;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (expired) begin
          if (line) begin
            state_d = S_IDLE;           // glitch, not a start bit
          end else begin
            cnt_d   = div_q;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (expired) begin
          shift_d = {line, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          cnt_d   = div_q;
          if (idx_q == 3'd7) begin
            state_d = (par_cfg_q == 2'b01 || par_cfg_q == 2'b10) ? S_PAR : S_STOP1;
          end
        end
      end
      S_PAR: begin
        if (expired) begin
          perr_d  = (par_cfg_q == 2'b10) ? par_xor : ~par_xor;
          cnt_d   = div_q;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (expired) begin
          if (stop_cfg_q) begin
            ferr_d  = ferr_sample;
            cnt_d   = div_q;
            state_d = S_STOP2;
          end else begin
            data_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_sample;
            valid_d    = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (expired) begin
          data_d     = shift_q;
          perr_out_d = perr_q;
          ferr_out_d = ferr_sample;
          valid_d    = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_decoder
//
// Directed bench for uart_decoder. Serial frames are built bit by bit on the
// falling clock edge. A monitor records every data_valid pulse, together with
// its cycle number and pulse width, so the stimulus process can compare them
// against hand-computed bytes and flags.
// -----------------------------------------------------------------------------
module tb_uart_decoder;

  localparam int BAUD_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              uart_dec;
  logic [1:0]        parity;
  logic              stop_sel;
  logic [BAUD_W-1:0] baudcontrol;
  logic [7:0]        data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  uart_decoder #(.BAUD_W(BAUD_W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_dec    (uart_dec),
    .parity      (parity),
    .stop_sel    (stop_sel),
    .baudcontrol (baudcontrol),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    int unsigned cyc;
  } rec_t;

  rec_t        rx_q[$];
  int unsigned cyc   = 0;
  int unsigned cur_w = 0;
  int unsigned max_w = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (data_valid) begin
      rx_q.push_back('{d: data_out, pe: parity_err, fe: frame_err, cyc: cyc});
      cur_w = cur_w + 1;
      if (cur_w > max_w) max_w = cur_w;
    end else begin
      cur_w = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] d,
                             input logic pe, input logic fe);
    if (idx >= rx_q.size()) begin
      check({tag, " missing"}, rx_q.size(), idx + 1);
    end else begin
      check({tag, " data"}, {24'd0, rx_q[idx].d}, {24'd0, d});
      check({tag, " perr"}, {31'd0, rx_q[idx].pe}, {31'd0, pe});
      check({tag, " ferr"}, {31'd0, rx_q[idx].fe}, {31'd0, fe});
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    uart_dec = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    send_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input bit has_par,
                            input logic par_bit, input int nstop,
                            input logic s1, input logic s2);
    send_bit(1'b0, n);
    for (int i = 0; i < 8; i++) send_bit(d[i], n);
    if (has_par) send_bit(par_bit, n);
    send_bit(s1, n);
    if (nstop == 2) send_bit(s2, n);
    uart_dec = 1'b1;
  endtask

  task automatic configure(input logic [1:0] p, input logic s, input logic [BAUD_W-1:0] b);
    parity      = p;
    stop_sel    = s;
    baudcontrol = b;
  endtask

  initial begin
    rst      = 1'b1;
    uart_dec = 1'b1;
    configure(2'b00, 1'b0, 24'd15);
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst data_out",   {24'd0, data_out}, 32'd0);
    check("rst data_valid", {31'd0, data_valid}, 32'd0);
    check("rst parity_err", {31'd0, parity_err}, 32'd0);
    check("rst frame_err",  {31'd0, frame_err}, 32'd0);
    check("rst busy",       {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(10);

    // Back-to-back 0x55, 0xA3 with no parity and one stop bit: 10 bits of 16 cycles each.
    rx_q.delete();
    max_w = 0;
    send_frame(8'h55, 16, 0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(8'hA3, 16, 0, 1'b0, 1, 1'b1, 1'b1);
    idle(40);
    check("b2b count", rx_q.size(), 2);
    check_frame("b2b 0x55", 0, 8'h55, 1'b0, 1'b0);
    check_frame("b2b 0xA3", 1, 8'hA3, 1'b0, 1'b0);
    if (rx_q.size() == 2) check("b2b spacing", rx_q[1].cyc - rx_q[0].cyc, 160);
    check("b2b pulse width", max_w, 1);

    // Even parity: 0x07 has three ones, so parity bit 1 is correct and 0 is wrong.
    configure(2'b10, 1'b0, 24'd15);
    rx_q.delete();
    send_frame(8'h07, 16, 1, 1'b1, 1, 1'b1, 1'b1);
    idle(20);
    send_frame(8'h07, 16, 1, 1'b0, 1, 1'b1, 1'b1);
    idle(20);
    check("even count", rx_q.size(), 2);
    check_frame("even ok",  0, 8'h07, 1'b0, 1'b0);
    check_frame("even bad", 1, 8'h07, 1'b1, 1'b0);

    // Odd parity with two stop bits: a low second stop bit gives frame_err.
    // 0x3C and 0x81 both have an even number of ones, so parity bit 1.
    configure(2'b01, 1'b1, 24'd15);
    rx_q.delete();
    send_frame(8'h3C, 16, 1, 1'b1, 2, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h81, 16, 1, 1'b1, 2, 1'b1, 1'b1);
    idle(20);
    check("odd count", rx_q.size(), 2);
    check_frame("odd stop2 low", 0, 8'h3C, 1'b0, 1'b1);
    check_frame("odd clean",     1, 8'h81, 1'b0, 1'b0);

    // Glitch: 5 low cycles end before the START sample, 7 cycles after detection.
    configure(2'b00, 1'b0, 24'd15);
    rx_q.delete();
    uart_dec = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch busy rise", {31'd0, busy}, 32'd1);
    uart_dec = 1'b1;
    repeat (11) @(negedge clk);
    check("glitch busy fall", {31'd0, busy}, 32'd0);
    idle(40);
    check("glitch no frame", rx_q.size(), 0);
    send_frame(8'h12, 16, 0, 1'b0, 1, 1'b1, 1'b1);
    idle(20);
    check("post-glitch count", rx_q.size(), 1);
    check_frame("post-glitch 0x12", 0, 8'h12, 1'b0, 1'b0);

    // Break: 30 bit times low gives one all-zero frame with frame_err and no retrigger.
    rx_q.delete();
    uart_dec = 1'b0;
    repeat (30 * 16) @(negedge clk);
    check("break busy idle", {31'd0, busy}, 32'd0);
    idle(100);
    check("break count", rx_q.size(), 1);
    check_frame("break frame", 0, 8'h00, 1'b0, 1'b1);
    send_frame(8'hC3, 16, 0, 1'b0, 1, 1'b1, 1'b1);
    idle(20);
    check_frame("post-break 0xC3", 1, 8'hC3, 1'b0, 1'b0);

    // Reset during the 4th data bit of 0xFF.
    rx_q.delete();
    send_bit(1'b0, 16);
    send_bit(1'b1, 3 * 16 + 8);
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mid-rst busy", {31'd0, busy}, 32'd0);
    check("mid-rst data_out", {24'd0, data_out}, 32'd0);
    idle(200);
    check("mid-rst no frame", rx_q.size(), 0);
    send_frame(8'h5A, 16, 0, 1'b0, 1, 1'b1, 1'b1);
    idle(20);
    check("post-rst count", rx_q.size(), 1);
    check_frame("post-rst 0x5A", 0, 8'h5A, 1'b0, 1'b0);

    // baudcontrol=1 is clamped to 3: 4-cycle bits, frames 40 cycles apart.
    configure(2'b00, 1'b0, 24'd1);
    rx_q.delete();
    send_frame(8'h96, 4, 0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(8'h3C, 4, 0, 1'b0, 1, 1'b1, 1'b1);
    idle(20);
    check("clamp count", rx_q.size(), 2);
    check_frame("clamp 0x96", 0, 8'h96, 1'b0, 1'b0);
    check_frame("clamp 0x3C", 1, 8'h3C, 1'b0, 1'b0);
    if (rx_q.size() == 2) check("clamp spacing", rx_q[1].cyc - rx_q[0].cyc, 40);

    check("final pulse width", max_w, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_decoder.md
Name: uart_decoder

Overview:
- UART receive-side decoder: deserialises one asynchronous serial line into bytes.
- Programmed with the same configuration fields as the team's UART encoder: parity mode, stop-bit select, baud divisor.
- Used in the SoC peripheral block as the RX path.
- Used in benches to check the core's UART TX output in place of hand-written shift-register checkers.

Parameters:
- BAUD_W, 24, width of baudcontrol.
- SYNC_STAGES, 2, flip-flops in the input synchroniser (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous assert, active-high.
- uart_dec  input  1  serial line; idle high; LSB first.
- parity  input  2  00 none, 01 odd, 10 even, 11 none.
- stop_sel  input  1  0: one stop bit, 1: two stop bits.
- baudcontrol  input  BAUD_W  bit period minus one, in clk cycles (e.g. 5207 gives 9600 bps at 50 MHz).
- data_out  output  8  last received byte.
- data_valid  output  1  one-cycle pulse: new byte and flags valid.
- parity_err  output  1  parity mismatch for the byte flagged by data_valid.
- frame_err  output  1  a stop bit sampled low for that byte.
- busy  output  1  high while any state other than IDLE.

Behaviour:
- Reset:
  - Synchroniser flops reset to 1; state is IDLE.
  - data_out=0; data_valid, parity_err, frame_err, busy all 0.
  - Bit counter, shift register and latched configuration all 0.
- Input path: uart_dec passes through SYNC_STAGES flops, then one extra edge-detect flop. Every reference to "line" below means the synchronised value.
- Effective divisor: D = max(baudcontrol, 3). Bit period is D+1 cycles. The down-counter decrements every cycle and "expires" when it reaches 0.
- State machine: IDLE, START, DATA, PAR, STOP1, STOP2.
- IDLE:
  - Leaves only on a falling edge (previous synchronised sample 1, current 0). A line held low, such as a break, never retriggers.
  - On the edge: latch parity, stop_sel and D; load counter with D>>1; go to START.
  - Configuration changes mid-frame have no effect until the next start.
- START: on expiry (mid start-bit), sample the line.
  - Line is 1: glitch; return to IDLE with no outputs.
  - Line is 0: load counter with D, clear the bit index, go to DATA.
- DATA:
  - On each expiry, shift the sampled bit into the MSB of an 8-bit shift register (LSB-first reception), increment the index and reload the counter with D.
  - After the 8th sample, go to PAR if latched parity is 01 or 10, otherwise go to STOP1.
- PAR: on expiry, sample the parity bit and compute the error.
  - Even (10): error if the XOR of the 8 data bits and the parity bit is 1.
  - Odd (01): error if that XOR is 0.
  - Reload the counter and go to STOP1.
- STOP1: on expiry, sample the line; a 0 sets the internal frame error.
  - Latched stop_sel=1: reload the counter and go to STOP2.
  - Otherwise: complete the frame.
- STOP2: on expiry, sample the line (0 sets the frame error), then complete the frame.
- Frame completion, on the cycle after the final stop sample:
  - data_out takes the shift register; parity_err and frame_err take the frame's flags; data_valid=1 for exactly one cycle.
  - State returns to IDLE on the same edge that registers the outputs.
  - data_out, parity_err and frame_err hold their values until the next completion.
- Bytes with errors are still delivered; the flags qualify them.
- Re-arm: because IDLE is re-entered at mid-stop-bit, a start bit beginning immediately after the stop bit is detected with no lost frame.
- Latency: the line's start falling edge reaches IDLE detection SYNC_STAGES+1 cycles later. data_valid rises exactly 1 cycle after the final stop-bit sample.
- Sample points: all samples after the start bit fall at (D>>1) + k·(D+1) cycles after detection, k = 1, 2, …
- rst asserted mid-frame: immediate return to reset values. The partial byte is discarded and no data_valid is produced.
- busy is registered and equals (state != IDLE).

Test Plan:
- baudcontrol=15, parity=00, stop_sel=0; send 0x55 then 0xA3 back-to-back with no idle gap → two data_valid pulses carrying 0x55 and 0xA3, no flags raised, each pulse exactly 1 cycle wide, spacing 160 cycles.
- parity=10 (even); send 0x07 with parity bit 1, then 0x07 with parity bit 0 → first byte has parity_err=0, second has parity_err=1; data_out=0x07 both times.
- parity=01, stop_sel=1; second stop bit driven low, byte 0x3C → data_valid with data_out=0x3C and frame_err=1. Following a correct frame of 0x81, both flags are 0.
- Glitch: line low for 5 cycles with baudcontrol=15 → no data_valid; busy falls back to 0 by the START sample point. A subsequent valid 0x12 is received correctly.
- Break: line held low for 30 bit times → one frame with data_out=0x00 and frame_err=1, then no further data_valid until the line returns high and a new falling edge occurs.
- Assert rst for 2 cycles during the 4th data bit of 0xFF → busy=0 and data_out retains its reset value of 0; the next frame, 0x5A, decodes correctly. Also check baudcontrol=1 is treated as 3 (bit period 4 cycles).
